// File: rtl/dma_mem_port.sv
// dma_mem_port: arbitrates DMA (priority) and CPU accesses onto one single-port data RAM and runs the host-exchange window handshake.
// Optional feature: define DMA_MEM_PORT_RANGE_CHECK_EN to drop out-of-range DMA accesses and raise a sticky dma_err.
module dma_mem_port #(
    parameter int          WORD_SIZE     = 32,
    parameter int          MEM_DEPTH     = 4096,
    parameter logic [31:0] WIN_BASE      = 32'h5000,
    parameter int          WIN_WORDS     = 16,
    parameter logic [31:0] DOORBELL_ADDR = 32'hFF00,
    parameter logic [31:0] STATUS_ADDR   = 32'hFF04,
    localparam int         AW            = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 DMAEn,
    input  logic                 DMAWrEn,
    input  logic [31:0]          DMAAddr,
    input  logic [WORD_SIZE-1:0] data_to_mem,
    output logic                 DMAValid,
    output logic [WORD_SIZE-1:0] data_to_host,
    output logic                 wr_ready,
    output logic                 cpu_init,
    input  logic                 cpu_en,
    input  logic                 cpu_wr_en,
    input  logic [31:0]          cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_valid,
    output logic                 cpu_stall,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 dma_err
);

    localparam int            CW       = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN_WORDS - 1);
    localparam logic [31:0]   WIN_END  = WIN_BASE + 32'(4 * WIN_WORDS);

    typedef enum logic {IDLE, UPLOAD} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          rd_cnt, wr_cnt;
    logic                   rd_cnt_clr, rd_cnt_inc;
    logic                   dma_in_range, dma_grant;
    logic                   win_hit, win_rd, win_wr, wrap_set;
    logic                   cpu_is_doorbell, cpu_is_status, cpu_ram_req, cpu_grant;
    logic                   doorbell_wr, status_rd, cpu_rd_accept;
    logic                   dma_rd_q, dma_zero_q, cpu_rd_q, cpu_from_ram_q;
    logic [WORD_SIZE-1:0]   status_word, status_q;
    logic                   dma_err_q;

`ifdef DMA_MEM_PORT_RANGE_CHECK_EN
    localparam logic [32:0] DMA_LIMIT = 33'(4 * MEM_DEPTH);
    logic dma_oor;

    assign dma_in_range = ({1'b0, DMAAddr} < DMA_LIMIT);
    assign dma_oor      = rst_n & DMAEn & ~dma_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n)
            dma_err_q <= 1'b0;
        else if (dma_oor)
            dma_err_q <= 1'b1;
        else if (status_rd)
            dma_err_q <= 1'b0;
    end
`else
    assign dma_in_range = 1'b1;
    assign dma_err_q    = 1'b0;
`endif

    assign dma_err = dma_err_q;

    assign win_hit         = (DMAAddr >= WIN_BASE) && (DMAAddr < WIN_END);
    assign win_rd          = DMAEn & ~DMAWrEn & win_hit;
    assign win_wr          = DMAEn & DMAWrEn & win_hit;
    assign wrap_set        = win_wr & (wr_cnt == CNT_LAST);
    assign dma_grant       = rst_n & DMAEn & dma_in_range;

    // Doorbell and status live outside the RAM, so they never compete with DMA.
    assign cpu_is_doorbell = (cpu_addr == DOORBELL_ADDR);
    assign cpu_is_status   = (cpu_addr == STATUS_ADDR);
    assign cpu_ram_req     = cpu_en & ~cpu_is_doorbell & ~cpu_is_status;
    assign cpu_stall       = rst_n & cpu_ram_req & DMAEn;
    assign cpu_grant       = rst_n & cpu_ram_req & ~DMAEn;
    assign doorbell_wr     = cpu_en & cpu_wr_en & cpu_is_doorbell;
    assign status_rd       = cpu_en & ~cpu_wr_en & cpu_is_status;
    assign cpu_rd_accept   = cpu_en & ~cpu_wr_en & ~cpu_stall;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_grant) begin
            mem_en    = 1'b1;
            mem_we    = DMAWrEn;
            mem_addr  = DMAAddr[2 +: AW];
            mem_wdata = data_to_mem;
        end else if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_wr_en;
            mem_addr  = cpu_addr[2 +: AW];
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[2:0] = {dma_err_q, wr_ready, cpu_init};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (doorbell_wr) state_next = UPLOAD;
            UPLOAD:  if (win_rd && (rd_cnt == CNT_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready   = (state == UPLOAD);
        rd_cnt_clr = (state == IDLE) & doorbell_wr;
        rd_cnt_inc = (state == UPLOAD) & win_rd;
    end

    // A set on the wrapping window write takes precedence over a status-read clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            cpu_init <= 1'b0;
        end else begin
            if (rd_cnt_clr)
                rd_cnt <= '0;
            else if (rd_cnt_inc)
                rd_cnt <= rd_cnt + 1'b1;
            if (win_wr)
                wr_cnt <= (wr_cnt == CNT_LAST) ? '0 : wr_cnt + 1'b1;
            if (wrap_set)
                cpu_init <= 1'b1;
            else if (status_rd)
                cpu_init <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dma_rd_q       <= 1'b0;
            dma_zero_q     <= 1'b0;
            cpu_rd_q       <= 1'b0;
            cpu_from_ram_q <= 1'b0;
            status_q       <= '0;
        end else begin
            dma_rd_q       <= DMAEn & ~DMAWrEn;
            dma_zero_q     <= DMAEn & ~DMAWrEn & ~dma_in_range;
            cpu_rd_q       <= cpu_rd_accept;
            cpu_from_ram_q <= cpu_rd_accept & cpu_ram_req;
            status_q       <= status_rd ? status_word : '0;
        end
    end

    assign DMAValid     = dma_rd_q;
    assign data_to_host = (dma_rd_q & ~dma_zero_q) ? mem_rdata : '0;
    assign cpu_valid    = cpu_rd_q;
    assign cpu_rdata    = cpu_from_ram_q ? mem_rdata : status_q;

endmodule

// File: tb/tb_dma_mem_port.sv
// tb_dma_mem_port: self-checking bench for dma_mem_port with a bench-owned RAM and an address-level reference model.
module tb_dma_mem_port;

    localparam int          WORD_SIZE = 32;
    localparam int          MEM_DEPTH = 4096;
    localparam int          WIN_WORDS = 16;
    localparam logic [31:0] WIN_BASE  = 32'h5000;
    localparam logic [31:0] DOORBELL  = 32'hFF00;
    localparam logic [31:0] STATUS    = 32'hFF04;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DMAEn = 1'b0, DMAWrEn = 1'b0;
    logic [31:0] DMAAddr = '0, data_to_mem = '0;
    logic        DMAValid;
    logic [31:0] data_to_host;
    logic        wr_ready, cpu_init;
    logic        cpu_en = 1'b0, cpu_wr_en = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_valid, cpu_stall;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        dma_err;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] ram       [MEM_DEPTH] = '{default: '0};
    logic [31:0] model_mem [MEM_DEPTH] = '{default: '0};
    bit          m_init = 0, m_ready = 0, m_err = 0;
    int          m_wr_count = 0;

    dma_mem_port dut (
        .clk(clk), .rst_n(rst_n),
        .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .data_to_mem(data_to_mem),
        .DMAValid(DMAValid), .data_to_host(data_to_host),
        .wr_ready(wr_ready), .cpu_init(cpu_init),
        .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_err(dma_err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM answering the DUT's mem_* port.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    function automatic bit in_range(input logic [31:0] a);
`ifdef DMA_MEM_PORT_RANGE_CHECK_EN
        return a < 32'(4 * MEM_DEPTH);
`else
        return (a == a);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MEM_DEPTH);
    endfunction

    function automatic logic [31:0] status_exp();
        return {29'b0, m_err, m_ready, m_init};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        DMAEn = 0; DMAWrEn = 0; DMAAddr = '0; data_to_mem = '0;
        cpu_en = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    // Window write through the model: RAM update, delivery count, out-of-range flag.
    task automatic model_dma_write(input logic [31:0] a, input logic [31:0] d);
        if (in_range(a)) model_mem[widx(a)] = d;
        else m_err = 1;
        if (a >= WIN_BASE && a < WIN_BASE + 4 * WIN_WORDS) begin
            m_wr_count++;
            if (m_wr_count % WIN_WORDS == 0) m_init = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; DMAEn = 1; DMAWrEn = 1; DMAAddr = 32'h40; cpu_en = 1; cpu_addr = 32'h100;
        #1;
        n_compared++; if (mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_en: got %0h expected 0", mem_en); end
        n_compared++; if (cpu_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_cpu_stall: got %0h expected 0", cpu_stall); end
        step();
        idle_inputs();
        #1;
        n_compared++; if (DMAValid !== 1'b0 || data_to_host !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_dma_resp: got %0h/%0h expected 0/0", DMAValid, data_to_host); end
        n_compared++; if (cpu_valid !== 1'b0 || cpu_rdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_cpu_resp: got %0h/%0h expected 0/0", cpu_valid, cpu_rdata); end
        n_compared++; if ({wr_ready, cpu_init, dma_err} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %0b expected 000", {wr_ready, cpu_init, dma_err}); end
        rst_n = 1;
        m_init = 0; m_ready = 0; m_err = 0; m_wr_count = 0;
        step();
    endtask

    task automatic test_line_delivery();
        logic [31:0] a;
        for (int i = 0; i < WIN_WORDS; i++) begin
            a = WIN_BASE + 32'(4 * i);
            DMAEn = 1; DMAWrEn = 1; DMAAddr = a; data_to_mem = 32'hA0 + 32'(i);
            #1;
            n_compared++; if (mem_en !== in_range(a)) begin n_mismatched++; $display("[TB] FAIL line_mem_en[%0d]: got %0h expected %0h", i, mem_en, in_range(a)); end
            if (in_range(a)) begin
                n_compared++; if (mem_we !== 1'b1 || mem_addr !== 12'(widx(a)) || mem_wdata !== data_to_mem) begin n_mismatched++; $display("[TB] FAIL line_mem_port[%0d]: got we=%0h addr=%0h data=%0h expected 1/%0h/%0h", i, mem_we, mem_addr, mem_wdata, widx(a), data_to_mem); end
            end
            n_compared++; if (cpu_init !== 1'b0) begin n_mismatched++; $display("[TB] FAIL line_early_init[%0d]: got %0h expected 0", i, cpu_init); end
            model_dma_write(a, data_to_mem);
            step();
        end
        idle_inputs();
        n_compared++; if (cpu_init !== m_init) begin n_mismatched++; $display("[TB] FAIL line_cpu_init: got %0h expected %0h", cpu_init, m_init); end
        for (int i = 0; i < WIN_WORDS; i++) begin
            a = WIN_BASE + 32'(4 * i);
            n_compared++; if (ram[widx(a)] !== model_mem[widx(a)]) begin n_mismatched++; $display("[TB] FAIL line_ram[%0h]: got %0h expected %0h", widx(a), ram[widx(a)], model_mem[widx(a)]); end
        end
        cpu_en = 1; cpu_wr_en = 0; cpu_addr = STATUS;
        #1;
        n_compared++; if (cpu_stall !== 1'b0 || mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL status_no_ram: got stall=%0h mem_en=%0h expected 0/0", cpu_stall, mem_en); end
        step();
        idle_inputs();
        n_compared++; if (cpu_valid !== 1'b1 || cpu_rdata !== status_exp()) begin n_mismatched++; $display("[TB] FAIL status_read: got %0h/%0h expected 1/%0h", cpu_valid, cpu_rdata, status_exp()); end
        m_init = 0; m_err = 0;
        n_compared++; if (cpu_init !== m_init || dma_err !== m_err) begin n_mismatched++; $display("[TB] FAIL status_clear: got init=%0h err=%0h expected %0h/%0h", cpu_init, dma_err, m_init, m_err); end
    endtask

    task automatic test_upload();
        logic [31:0] a, exp_d;
        cpu_en = 1; cpu_wr_en = 1; cpu_addr = DOORBELL; cpu_wdata = $urandom;
        #1;
        n_compared++; if (wr_ready !== 1'b0 || cpu_stall !== 1'b0 || mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL doorbell_cycle: got ready=%0h stall=%0h mem_en=%0h expected 0/0/0", wr_ready, cpu_stall, mem_en); end
        step();
        idle_inputs();
        m_ready = 1;
        n_compared++; if (wr_ready !== m_ready) begin n_mismatched++; $display("[TB] FAIL doorbell_ready: got %0h expected %0h", wr_ready, m_ready); end
        for (int i = 0; i <= WIN_WORDS; i++) begin
            a = WIN_BASE + 32'(4 * i);
            if (i < WIN_WORDS) begin DMAEn = 1; DMAWrEn = 0; DMAAddr = a; end
            else DMAEn = 0;
            if (i == 5) begin cpu_en = 1; cpu_wr_en = 1; cpu_addr = DOORBELL; end
            else cpu_en = 0;
            exp_d = in_range(a) ? model_mem[widx(a)] : 32'h0;
            step();
            if (i < WIN_WORDS) begin
                if (i == WIN_WORDS - 1) m_ready = 0;
                n_compared++; if (DMAValid !== 1'b1 || data_to_host !== exp_d) begin n_mismatched++; $display("[TB] FAIL upload_read[%0d]: got %0h/%0h expected 1/%0h", i, DMAValid, data_to_host, exp_d); end
                n_compared++; if (wr_ready !== m_ready) begin n_mismatched++; $display("[TB] FAIL upload_ready[%0d]: got %0h expected %0h", i, wr_ready, m_ready); end
            end else begin
                n_compared++; if (DMAValid !== 1'b0 || data_to_host !== 32'h0) begin n_mismatched++; $display("[TB] FAIL upload_tail: got %0h/%0h expected 0/0", DMAValid, data_to_host); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [31:0] v, exp_d;
        v = $urandom;
        DMAEn = 1; DMAWrEn = 1; DMAAddr = 32'h100; data_to_mem = v;
        model_dma_write(32'h100, v);
        step();
        DMAEn = 1; DMAWrEn = 0; DMAAddr = WIN_BASE; cpu_en = 1; cpu_wr_en = 0; cpu_addr = 32'h100;
        exp_d = in_range(WIN_BASE) ? model_mem[widx(WIN_BASE)] : 32'h0;
        #1;
        n_compared++; if (cpu_stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL contend_stall: got %0h expected 1", cpu_stall); end
        n_compared++; if (mem_en !== in_range(WIN_BASE) || mem_addr !== (in_range(WIN_BASE) ? 12'(widx(WIN_BASE)) : 12'h0)) begin n_mismatched++; $display("[TB] FAIL contend_dma_grant: got en=%0h addr=%0h", mem_en, mem_addr); end
        step();
        DMAEn = 0;
        #1;
        n_compared++; if (DMAValid !== 1'b1 || data_to_host !== exp_d || cpu_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL contend_dma_first: got %0h/%0h cpu_valid=%0h expected 1/%0h/0", DMAValid, data_to_host, cpu_valid, exp_d); end
        n_compared++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h040) begin n_mismatched++; $display("[TB] FAIL contend_cpu_grant: got stall=%0h en=%0h we=%0h addr=%0h expected 0/1/0/40", cpu_stall, mem_en, mem_we, mem_addr); end
        step();
        idle_inputs();
        n_compared++; if (cpu_valid !== 1'b1 || cpu_rdata !== v || DMAValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL contend_cpu_read: got %0h/%0h dma_valid=%0h expected 1/%0h/0", cpu_valid, cpu_rdata, DMAValid, v); end
    endtask

    task automatic test_back_to_back();
        bit          hold = 0, stall_exp, nd_val, nc_val;
        logic [31:0] nd_data, nc_data;
        for (int c = 0; c < 300; c++) begin
            DMAEn = 1'($urandom_range(0, 1)); DMAWrEn = 1'($urandom_range(0, 1));
            DMAAddr = 32'($urandom_range(0, 63)) * 4; data_to_mem = $urandom;
            if (!hold) begin
                cpu_en = 1'($urandom_range(0, 1)); cpu_wr_en = 1'($urandom_range(0, 1));
                cpu_addr = 32'($urandom_range(0, 63)) * 4; cpu_wdata = $urandom;
            end
            #1;
            stall_exp = cpu_en && DMAEn;
            n_compared++; if (cpu_stall !== stall_exp) begin n_mismatched++; $display("[TB] FAIL b2b_stall[%0d]: got %0h expected %0h", c, cpu_stall, stall_exp); end
            nd_val  = DMAEn && !DMAWrEn;
            nd_data = nd_val ? model_mem[widx(DMAAddr)] : 32'h0;
            nc_val  = cpu_en && !cpu_wr_en && !stall_exp;
            nc_data = nc_val ? model_mem[widx(cpu_addr)] : 32'h0;
            if (DMAEn && DMAWrEn) model_mem[widx(DMAAddr)] = data_to_mem;
            if (cpu_en && cpu_wr_en && !stall_exp) model_mem[widx(cpu_addr)] = cpu_wdata;
            hold = stall_exp;
            step();
            n_compared++; if (DMAValid !== nd_val || data_to_host !== nd_data) begin n_mismatched++; $display("[TB] FAIL b2b_dma[%0d]: got %0h/%0h expected %0h/%0h", c, DMAValid, data_to_host, nd_val, nd_data); end
            n_compared++; if (cpu_valid !== nc_val || cpu_rdata !== nc_data) begin n_mismatched++; $display("[TB] FAIL b2b_cpu[%0d]: got %0h/%0h expected %0h/%0h", c, cpu_valid, cpu_rdata, nc_val, nc_data); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_range();
        logic [31:0] v, a, exp_d;
        a = 32'h4000;
        v = $urandom;
        DMAEn = 1; DMAWrEn = 1; DMAAddr = a; data_to_mem = v;
        #1;
        n_compared++; if (mem_en !== in_range(a)) begin n_mismatched++; $display("[TB] FAIL range_mem_en: got %0h expected %0h", mem_en, in_range(a)); end
        if (in_range(a)) begin
            n_compared++; if (mem_addr !== 12'(widx(a))) begin n_mismatched++; $display("[TB] FAIL range_wrap_addr: got %0h expected %0h", mem_addr, widx(a)); end
        end
        model_dma_write(a, v);
        step();
        DMAEn = 1; DMAWrEn = 0; DMAAddr = a;
        exp_d = in_range(a) ? model_mem[widx(a)] : 32'h0;
        n_compared++; if (dma_err !== m_err) begin n_mismatched++; $display("[TB] FAIL range_err: got %0h expected %0h", dma_err, m_err); end
        n_compared++; if (ram[0] !== model_mem[0]) begin n_mismatched++; $display("[TB] FAIL range_ram0: got %0h expected %0h", ram[0], model_mem[0]); end
        step();
        idle_inputs();
        n_compared++; if (DMAValid !== 1'b1 || data_to_host !== exp_d) begin n_mismatched++; $display("[TB] FAIL range_read: got %0h/%0h expected 1/%0h", DMAValid, data_to_host, exp_d); end
        cpu_en = 1; cpu_wr_en = 0; cpu_addr = STATUS;
        step();
        idle_inputs();
        n_compared++; if (cpu_rdata !== status_exp()) begin n_mismatched++; $display("[TB] FAIL range_status: got %0h expected %0h", cpu_rdata, status_exp()); end
        m_err = 0; m_init = 0;
        n_compared++; if (dma_err !== m_err) begin n_mismatched++; $display("[TB] FAIL range_err_clear: got %0h expected %0h", dma_err, m_err); end
    endtask

    task automatic test_reset_midline();
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            a = WIN_BASE + 32'(4 * i);
            DMAEn = 1; DMAWrEn = 1; DMAAddr = a; data_to_mem = $urandom;
            model_dma_write(a, data_to_mem);
            step();
        end
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        m_wr_count = 0; m_init = 0; m_ready = 0; m_err = 0;
        n_compared++; if (cpu_init !== m_init || dma_err !== m_err) begin n_mismatched++; $display("[TB] FAIL midline_reset: got init=%0h err=%0h expected %0h/%0h", cpu_init, dma_err, m_init, m_err); end
        for (int i = 0; i < WIN_WORDS; i++) begin
            a = WIN_BASE + 32'(4 * ((i + 3) % WIN_WORDS));
            DMAEn = 1; DMAWrEn = 1; DMAAddr = a; data_to_mem = $urandom;
            model_dma_write(a, data_to_mem);
            step();
            n_compared++; if (cpu_init !== m_init) begin n_mismatched++; $display("[TB] FAIL midline_init[%0d]: got %0h expected %0h", i, cpu_init, m_init); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_line_delivery();
        test_upload();
        test_contention();
        test_back_to_back();
        test_range();
        test_reset_midline();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
